// File: rtl/mul_mont_sched.sv
// Round-robin issue scheduler in front of a fixed-latency Montgomery multiplier.
// Requester IDs ride the multiplier sideband; results land in a credit-protected show-ahead FIFO.
module mul_mont_sched #(
  parameter  int NREQ    = 4,
  parameter  int WI      = 382,
  parameter  int MUL_LAT = 40,
  parameter  int DEPTH   = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WI-1:0]   req_a,
  input  logic [NREQ*WI-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WI-1:0]        rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [WI-1:0]        mul_in0,
  output logic [WI-1:0]        mul_in1,
  output logic [IDW:0]         mul_m_i,
  input  logic [IDW:0]         mul_m_o,
  input  logic [WI-1:0]        mul_out0,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WI-1:0]  data;
  } ent_t;

  logic [NREQ-1:0][WI-1:0] a_v, b_v;
  assign a_v = req_a;
  assign b_v = req_b;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  out_q, out_d;
  logic [WI-1:0]  in0_q, in0_d, in1_q, in1_d;
  logic [IDW:0]   mi_q, mi_d;
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
  ent_t           fifo_mem [DEPTH];

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           issue_ok, xfer, push, pop, empty, full;
  ent_t           head;

  // Scan downward so the requester nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rr_ptr_q + IDW'(k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_ptr_q + IDW'(k);
      end
    end
  end

  assign issue_ok = (out_q < CW'(DEPTH));

  // Gated by reset so the grant vector is quiet while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && issue_ok && gnt_found) req_ready = NREQ'(1) << gnt_idx;
  end

  assign xfer  = |(req_valid & req_ready);
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = mul_m_o[IDW];
  assign pop   = rsp_valid && rsp_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    mi_d     = {1'b0, mi_q[IDW-1:0]};
    if (xfer) begin
      rr_ptr_d = gnt_idx + IDW'(1);
      in0_d    = a_v[gnt_idx];
      in1_d    = b_v[gnt_idx];
      mi_d     = {1'b1, gnt_idx};
    end
  end

  // Credits cover ops in the multiplier plus entries parked in the FIFO.
  always_comb begin
    unique case ({xfer, pop})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + (AW+1)'(1);
    if (pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      out_q    <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      mi_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      mi_q     <= mi_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q[AW-1:0]] <= '{id: mul_m_o[IDW-1:0], data: mul_out0};
  end

  assign head      = fifo_mem[rd_q[AW-1:0]];
  assign rsp_valid = !empty;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_id    = rsp_valid ? head.id   : '0;

  assign mul_in0 = in0_q;
  assign mul_in1 = in1_q;
  assign mul_m_i = mi_q;
  assign busy    = (out_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full))
    else $error("result pushed into a full FIFO");

endmodule

// File: tb/tb_mul_mont_sched.sv
// Bench for mul_mont_sched: behavioural multiplier, cycle-level scoreboard, table plus directed sequences.
module tb_mul_mont_sched;
  localparam int NREQ = 4, WI = 32, MUL_LAT = 40, DEPTH = 64, IDW = 2;
  localparam logic [WI-1:0] Q     = 32'hFFFF_FFFB;  // 2^32-5, prime
  localparam logic [WI-1:0] RMODQ = 32'd5;          // 2^32 mod Q

  logic clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ-1:0][WI-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready = 1'b1, busy;
  logic [WI-1:0] rsp_data, mul_in0, mul_in1, mul_out0;
  logic [IDW-1:0] rsp_id;
  logic [IDW:0] mul_m_i, mul_m_o;

  mul_mont_sched #(.NREQ(NREQ), .WI(WI), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .mul_in0(mul_in0), .mul_in1(mul_in1),
    .mul_m_i(mul_m_i), .mul_m_o(mul_m_o), .mul_out0(mul_out0), .busy(busy));

  always #5 clk = ~clk;

  // Bit-serial REDC: a*b*2^-WI mod Q.
  function automatic logic [WI-1:0] mont(input logic [WI-1:0] a, input logic [WI-1:0] b);
    logic [2*WI+1:0] wa, wb, t;
    wa = {34'd0, a};
    wb = {34'd0, b};
    t  = wa * wb;
    for (int i = 0; i < WI; i++) begin
      if (t[0]) t = t + {34'd0, Q};
      t = t >> 1;
    end
    if (t >= {34'd0, Q}) t = t - {34'd0, Q};
    return t[WI-1:0];
  endfunction

  typedef struct packed { logic v; logic [IDW-1:0] id; logic [WI-1:0] d; } mst_t;
  mst_t mpipe [MUL_LAT];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= '{v: mul_m_i[IDW], id: mul_m_i[IDW-1:0], d: mont(mul_in0, mul_in1)};
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_m_o  = {mpipe[MUL_LAT-1].v, mpipe[MUL_LAT-1].id};
  assign mul_out0 = mpipe[MUL_LAT-1].d;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: issue-ordered queue, outstanding = queue size.
  typedef struct { int unsigned t; logic [IDW-1:0] id; logic [WI-1:0] d; } exp_t;
  exp_t sb[$];
  exp_t h;
  int n_xfer = 0, m_ptr = 0, gi;
  int id_cnt [NREQ];
  logic gf, ev, m_last_v = 1'b0;
  logic [NREQ-1:0] er;
  logic [IDW-1:0] m_last_id;
  logic [WI-1:0] m_last_a, m_last_b;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outs", 64'({req_ready, rsp_valid, rsp_data, rsp_id, busy}), 64'd0);
      chk("reset_mul", {mul_in0, mul_in1}, 64'd0);
      chk("reset_m_i", 64'(mul_m_i), 64'd0);
      sb.delete();
      m_ptr = 0;
      m_last_v = 1'b0;
    end else begin
      gf = 1'b0; gi = 0;
      for (int k = 0; k < NREQ; k++)
        if (!gf && req_valid[(m_ptr + k) % NREQ]) begin gf = 1'b1; gi = (m_ptr + k) % NREQ; end
      er = (gf && sb.size() < DEPTH) ? NREQ'(1) << gi : '0;
      ev = (sb.size() > 0) && (cyc >= sb[0].t + MUL_LAT + 2);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(sb.size() != 0));
      chk("m_i_valid", 64'(mul_m_i[IDW]), 64'(m_last_v));
      if (m_last_v) begin
        chk("m_i_id", 64'(mul_m_i[IDW-1:0]), 64'(m_last_id));
        chk("mul_in", {mul_in0, mul_in1}, {m_last_a, m_last_b});
      end
      if (ev && rsp_ready) begin
        h = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(h.id));
        chk("rsp_data", 64'(rsp_data), 64'(h.d));
        id_cnt[h.id]++;
      end
      m_last_v = 1'b0;
      if (er != '0) begin
        sb.push_back('{t: cyc, id: IDW'(gi), d: mont(req_a[gi], req_b[gi])});
        m_ptr = (gi + 1) % NREQ;
        m_last_v = 1'b1; m_last_id = IDW'(gi);
        m_last_a = req_a[gi]; m_last_b = req_b[gi];
        n_xfer++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = $urandom % Q;
      req_b[i] = $urandom % Q;
    end
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0; rsp_ready = 1'b1;
    while (busy && n < 500) begin step(); n++; end
    if (busy) begin
      miscompares++;
      $display("FAIL drain_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic issue_n(input int cnt);
    int start = n_xfer, g = 0;
    req_valid = '1;
    while (n_xfer - start < cnt && g < 1000) begin step(); g++; end
    req_valid = '0;
    chk("issue_count", 64'(n_xfer - start), 64'(cnt));
  endtask

  typedef struct { int first; logic [NREQ-1:0] mask; logic [NREQ-1:0] exp_rdy; } gvec_t;
  gvec_t tbl [8];
  int t0, n, start;

  initial begin
    tbl[0] = '{0, 4'b1111, 4'b0010};
    tbl[1] = '{1, 4'b0011, 4'b0001};
    tbl[2] = '{3, 4'b1000, 4'b1000};
    tbl[3] = '{2, 4'b0110, 4'b0010};
    tbl[4] = '{0, 4'b0001, 4'b0001};
    tbl[5] = '{3, 4'b0000, 4'b0000};
    tbl[6] = '{1, 4'b1100, 4'b0100};
    tbl[7] = '{2, 4'b1001, 4'b1000};
    for (int i = 0; i < NREQ; i++) begin req_a[i] = '0; req_b[i] = '0; end

    repeat (3) step();
    req_valid = '1;
    #1 chk("reset_ready_held", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst = 1'b1;
    step();

    // Single request: Montgomery one squared stays Montgomery one.
    req_valid = 4'b0100; req_a[2] = RMODQ; req_b[2] = RMODQ; t0 = cyc;
    step(); req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    chk("single_latency", 64'(cyc - t0), 64'(MUL_LAT + 2));
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_data", 64'(rsp_data), 64'(RMODQ));
    step(); step();
    chk("single_busy_after", 64'(busy), 64'd0);

    // 400 ops, all requesters valid, full rate.
    drain();
    for (int i = 0; i < NREQ; i++) id_cnt[i] = 0;
    issue_n(400);
    drain();
    for (int i = 0; i < NREQ; i++) chk("per_id_count", 64'(id_cnt[i]), 64'd100);

    // Backpressure: exactly DEPTH accepted, then resume one grant per pop.
    drain();
    rsp_ready = 1'b0; start = n_xfer; req_valid = '1;
    repeat (100) step();
    chk("bp_accepted", 64'(n_xfer - start), 64'(DEPTH));
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    repeat (120) step();
    drain();

    // Transfer and pop together at DEPTH-1 keep the credit count still.
    rsp_ready = 1'b0;
    issue_n(DEPTH - 1);
    repeat (MUL_LAT + 5) step();
    req_valid = '1; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1 chk("at63_ready", 64'(req_ready != '0), 64'd1);
    step();
    #1 chk("at64_ready", 64'(req_ready), 64'd0);
    drain();

    // Sparse: only 3, then only 0 -- every cycle granted, pointer wraps.
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin #1 chk("sparse3", 64'(req_ready), 64'h8); step(); end
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin #1 chk("sparse0", 64'(req_ready), 64'h1); step(); end
    req_valid = '0;
    repeat (3) step();
    drain();

    // Table of grant patterns relative to the previous grant.
    for (int i = 0; i < 8; i++) begin
      req_valid = NREQ'(1) << tbl[i].first;
      step();
      req_valid = tbl[i].mask;
      #1 chk("grant_tbl", 64'(req_ready), 64'(tbl[i].exp_rdy));
      step();
      req_valid = '0;
    end
    drain();

    // Reset with 20 ops in flight.
    issue_n(20);
    repeat (5) step();
    #2 rst = 1'b0;
    #1 chk("rst_now_outs", 64'({rsp_valid, busy, req_ready, rsp_id}), 64'd0);
    chk("rst_now_mul", {mul_in0, mul_in1}, 64'd0);
    chk("rst_now_m_i", 64'(mul_m_i), 64'd0);
    step(); step();
    rst = 1'b1;
    repeat (MUL_LAT + 20) step();
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    issue_n(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
